// File: rtl/player_ctrl_pkg.sv
// Shared definitions for the player movement / game-flow controller.
//   state_t : FSM state codes, also exported on the debug/HUD state port
//   BTN_*   : one-hot direction masks, {U,D,R,L} = bits [3:0]
//   prioSel : reduces raw button levels to a single direction, U > D > R > L
package player_ctrl_pkg;

  localparam int unsigned BTN_W   = 4;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 3'd0,
    PLAY     = 3'd1,
    PAUSED   = 3'd2,
    DYING    = 3'd3,
    RESPAWN  = 3'd4,
    GAMEOVER = 3'd5
  } state_t;

  localparam logic [BTN_W-1:0] BTN_U = 4'd8;
  localparam logic [BTN_W-1:0] BTN_D = 4'd4;
  localparam logic [BTN_W-1:0] BTN_R = 4'd2;
  localparam logic [BTN_W-1:0] BTN_L = 4'd1;

  function automatic logic [BTN_W-1:0] prioSel(input logic [BTN_W-1:0] raw);
    if (raw[3])      return BTN_U;
    else if (raw[2]) return BTN_D;
    else if (raw[1]) return BTN_R;
    else if (raw[0]) return BTN_L;
    else             return '0;
  endfunction

endpackage

// File: rtl/btn_repeater.sv
// Turns held button levels into single-cycle one-hot move pulses: a pulse on
// each new press, then one every REPEAT_TICKS cycles while the press is held.
//   btnClk, rst  : clock, asynchronous active-high reset
//   btns_raw     : synchronised button levels {U,D,R,L}
//   enable       : high while moves are allowed; low clears all tracking
//   movePulse_c  : combinational one-hot pulse, registered by the caller
module btn_repeater
  import player_ctrl_pkg::*;
#(
  parameter int unsigned REPEAT_TICKS = 4
) (
  input  logic             btnClk,
  input  logic             rst,
  input  logic [BTN_W-1:0] btns_raw,
  input  logic             enable,
  output logic [BTN_W-1:0] movePulse_c
);

  localparam int unsigned CNT_W = 8;

  logic [BTN_W-1:0] held, heldN, sel;
  logic [CNT_W-1:0] repCnt, repCntN;
  logic             fired, firedN;

  always_ff @(posedge btnClk or posedge rst) begin
    if (rst) begin
      held   <= '0;
      repCnt <= '0;
      fired  <= 1'b0;
    end else begin
      held   <= heldN;
      repCnt <= repCntN;
      fired  <= firedN;
    end
  end

  // A pulse is never issued in the cycle right after another one; a blocked
  // press or repeat is retried on the next cycle by leaving the state as is.
  always_comb begin
    sel         = prioSel(btns_raw);
    heldN       = held;
    repCntN     = repCnt;
    movePulse_c = '0;
    if (!enable || sel == '0) begin
      heldN   = '0;
      repCntN = '0;
    end else if (sel != held) begin
      if (!fired) begin
        movePulse_c = sel;
        heldN       = sel;
        repCntN     = CNT_W'(REPEAT_TICKS);
      end
    end else if (repCnt <= CNT_W'(1)) begin
      if (!fired) begin
        movePulse_c = sel;
        repCntN     = CNT_W'(REPEAT_TICKS);
      end
    end else begin
      repCntN = repCnt - CNT_W'(1);
    end
    firedN = (movePulse_c != '0);
  end

endmodule

// File: rtl/player_move_ctrl.sv
// Game-flow controller for the player rectangle: move command generation,
// death filtering, lives, respawn and game-over sequencing.
//   btnClk, rst    : clock, asynchronous active-high reset
//   btns_raw       : synchronised button levels {U,D,R,L}
//   start, pause   : start/restart level; pause rising edge toggles pause
//   player_dead    : raw (glitchy) dead flag from the player block
//   btns           : one-hot single-cycle move command
//   playerDisable  : high whenever not in PLAY
//   playerRst      : one-cycle pulse sending the player to its start position
//   lives, gameOver, state : HUD / debug outputs
module player_move_ctrl
  import player_ctrl_pkg::*;
#(
  parameter int unsigned LIVES         = 3,
  parameter int unsigned DEAD_CONFIRM  = 2,
  parameter int unsigned REPEAT_TICKS  = 4,
  parameter int unsigned RESPAWN_TICKS = 8
) (
  input  logic                 btnClk,
  input  logic                 rst,
  input  logic [BTN_W-1:0]     btns_raw,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 player_dead,
  output logic [BTN_W-1:0]     btns,
  output logic                 playerDisable,
  output logic                 playerRst,
  output logic [3:0]           lives,
  output logic                 gameOver,
  output logic [STATE_W-1:0]   state
);

  localparam int unsigned DEAD_W = 4;
  localparam int unsigned RESP_W = 8;

  state_t            stateQ, stateN;
  logic [BTN_W-1:0]  btnsN, movePulse_c;
  logic              playerDisableN, playerRstN, gameOverN;
  logic [3:0]        livesN;
  logic [DEAD_W-1:0] deadCnt, deadCntN;
  logic [RESP_W-1:0] respCnt, respCntN;
  logic              pausePrev, pauseEdge;

  btn_repeater #(.REPEAT_TICKS(REPEAT_TICKS)) uRepeater (
    .btnClk      (btnClk),
    .rst         (rst),
    .btns_raw    (btns_raw),
    .enable      (stateQ == PLAY),
    .movePulse_c (movePulse_c)
  );

  assign state = stateQ;

  // State and registered outputs
  always_ff @(posedge btnClk or posedge rst) begin
    if (rst) begin
      stateQ        <= IDLE;
      btns          <= '0;
      playerDisable <= 1'b1;
      playerRst     <= 1'b0;
      lives         <= '0;
      gameOver      <= 1'b0;
      deadCnt       <= '0;
      respCnt       <= '0;
      pausePrev     <= 1'b0;
    end else begin
      stateQ        <= stateN;
      btns          <= btnsN;
      playerDisable <= playerDisableN;
      playerRst     <= playerRstN;
      lives         <= livesN;
      gameOver      <= gameOverN;
      deadCnt       <= deadCntN;
      respCnt       <= respCntN;
      pausePrev     <= pause;
    end
  end

  // Next state and outputs; in PLAY a confirmed death beats a pause edge,
  // which beats a move.
  always_comb begin
    stateN     = stateQ;
    btnsN      = '0;
    playerRstN = 1'b0;
    livesN     = lives;
    gameOverN  = gameOver;
    deadCntN   = '0;
    respCntN   = '0;
    pauseEdge  = pause && !pausePrev;
    case (stateQ)
      IDLE, GAMEOVER: begin
        if (start) begin
          stateN     = PLAY;
          livesN     = 4'(LIVES);
          playerRstN = 1'b1;
          gameOverN  = 1'b0;
        end
      end
      PLAY: begin
        // dead flag is not trusted while the player is being repositioned
        if (player_dead && !playerRst) begin
          deadCntN = (deadCnt >= DEAD_W'(DEAD_CONFIRM)) ? DEAD_W'(DEAD_CONFIRM)
                                                        : deadCnt + DEAD_W'(1);
        end
        if (deadCntN == DEAD_W'(DEAD_CONFIRM)) begin
          stateN   = DYING;
          deadCntN = '0;
        end else if (pauseEdge) begin
          stateN = PAUSED;
        end else begin
          btnsN = movePulse_c;
        end
      end
      PAUSED: begin
        if (pauseEdge) stateN = PLAY;
      end
      DYING: begin
        livesN = (lives == 4'd0) ? 4'd0 : lives - 4'd1;
        if (lives <= 4'd1) begin
          stateN    = GAMEOVER;
          gameOverN = 1'b1;
        end else begin
          stateN     = RESPAWN;
          playerRstN = 1'b1;
        end
      end
      RESPAWN: begin
        if (respCnt == RESP_W'(RESPAWN_TICKS - 1)) stateN = PLAY;
        else respCntN = respCnt + RESP_W'(1);
      end
      default: stateN = IDLE;
    endcase
    playerDisableN = (stateN != PLAY);
  end

endmodule

// File: doc/player_move_ctrl.md
Name: player_move_ctrl

Overview:
Game-flow controller that sequences the player rectangle datapath.
- Converts raw button levels into one-hot, single-cycle move commands, with press-edge detection and hold auto-repeat.
- Filters the player's combinational dead flag, tracks lives, and drives playerDisable and a position-reset pulse through the die/respawn/game-over flow.
- Sits between the button synchroniser and the player rectangle, on the button clock.

Parameters:
LIVES, 3, lives loaded on start; range 1..15.
DEAD_CONFIRM, 2, consecutive cycles player_dead must be high to register a death; range 1..15.
REPEAT_TICKS, 4, cycles between auto-repeat moves while a button is held; range 1..255.
RESPAWN_TICKS, 8, cycles spent in RESPAWN before play resumes; range 1..255.

Ports:
btnClk  in  1  sole clock.
rst  in  1  asynchronous, active-high reset.
btns_raw  in  4  synchronised button levels {U,D,R,L} = bits [3:0].
start  in  1  level; starts or restarts a game.
pause  in  1  level; rising edge toggles pause.
player_dead  in  1  dead flag from player block; may glitch.
btns  out  4  one-hot move command, high one cycle; 0 when idle.
playerDisable  out  1  high whenever state is not PLAY.
playerRst  out  1  one-cycle pulse; returns the player to its start position.
lives  out  4  remaining lives.
gameOver  out  1  high in GAMEOVER.
state  out  3  current state code, for debug and HUD.

Behaviour:
- Reset values:
  - state = IDLE.
  - btns = 0, playerRst = 0, lives = 0, gameOver = 0.
  - playerDisable = 1.
  - All counters and edge registers = 0.
- State encoding, shared package: IDLE=0, PLAY=1, PAUSED=2, DYING=3, RESPAWN=4, GAMEOVER=5. Codes 6 and 7 go to IDLE on the next cycle.
- Transitions:
  - IDLE or GAMEOVER, start=1 → PLAY. Same edge: lives <= LIVES, playerRst <= 1 for one cycle, gameOver <= 0.
  - PLAY, pause rising edge → PAUSED.
  - PAUSED, pause rising edge → PLAY. Move counters are cleared on entry to PAUSED.
  - PLAY, dead_cnt reaches DEAD_CONFIRM → DYING. The move command is suppressed that cycle.
  - DYING (exactly 1 cycle): lives <= lives-1. If lives was 1 → GAMEOVER, else → RESPAWN.
  - RESPAWN: playerRst high on the first cycle only. After RESPAWN_TICKS cycles → PLAY.
- Dead filter, in PLAY only:
  - dead_cnt increments while player_dead=1 and saturates at DEAD_CONFIRM.
  - It clears when player_dead=0, and in every other state.
  - player_dead is ignored in every state other than PLAY, including the playerRst cycle.
- Move generation, PLAY only, registered (one cycle after the sampled input):
  - Priority when several bits are high: U > D > R > L. The selected bit is sel.
  - A new press (sel differs from the previously held sel, and is nonzero) issues btns = sel immediately and loads rep_cnt = REPEAT_TICKS.
  - Same sel held: rep_cnt decrements. On reaching 0, issue btns = sel and reload rep_cnt.
  - sel = 0 clears rep_cnt and the held register.
- btns is 0 in all other states. It is never more than one-hot and is never high two cycles in a row.
- start in PLAY, PAUSED, DYING or RESPAWN is ignored (no mid-game restart).
- Simultaneous events in PLAY: a confirmed death beats a pause edge, and a pause edge beats a move.
- Reset mid-operation returns to IDLE immediately. No playerRst pulse is generated by reset itself.
- lives never underflows: DYING with lives=0 (unreachable) → GAMEOVER with lives held at 0.

Decomposition:
- Package player_ctrl_pkg holds:
  - the state codes;
  - direction masks BTN_U=8, BTN_D=4, BTN_R=2, BTN_L=1.
- One natural sub-module: btn_repeater. It takes btns_raw and an enable, and outputs the one-hot move pulse. It contains the priority select, edge detect and repeat counter.
- The top FSM instantiates btn_repeater with enable = (state == PLAY).

Test Plan:
- Reset then start=1 for 1 cycle → next cycle state=PLAY, lives=3, playerRst high exactly 1 cycle, playerDisable=0.
- Hold btns_raw=4'b1010 for 10 cycles in PLAY (REPEAT_TICKS=4) → btns=8 on cycles 1, 5 and 9 after the press; otherwise 0. Bit 1 is never issued.
- player_dead high 1 cycle, then low → no death. player_dead high 2 cycles → DYING, lives 3→2, then RESPAWN with playerRst pulse, back to PLAY 8 cycles later.
- Three confirmed deaths → GAMEOVER, gameOver=1, lives=0. A following start=1 → PLAY with lives=3.
- Pause rising edge while holding U → PAUSED, btns stays 0, playerDisable=1. Second edge → PLAY, and the still-held U issues a fresh move.
- Assert rst during RESPAWN → state=IDLE, btns=0, playerRst=0, playerDisable=1 in the same cycle (asynchronous).
